fclass_arbiter_16bit: RTL and testbench
=======================================

FCLASS_ARBITER_16BIT -- requirements
Module: fclass_arbiter_16bit

Interface
REQ-001 SHALL have parameter NREQ, default 4, giving the number of requesters sharing one half-precision classifier; legal range 2..8.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, NREQ bits: bit i set means requester i offers an operand.
REQ-005 SHALL have port req_float, input, NREQ*16 bits: operand of requester i in bits [16i+15:16i].
REQ-006 SHALL have port req_ready, output, NREQ bits: one-hot accept; requester i's operand is taken when req_valid[i] and req_ready[i] are both high.
REQ-007 SHALL have port resp_valid, output, 1 bit: a classification result is presented.
REQ-008 SHALL have port resp_id, output, $clog2(NREQ) bits: index of the requester that owns the result.
REQ-009 SHALL have port resp_class, output, 10 bits: one-hot classification of the accepted operand.
REQ-010 SHALL have port resp_ready, input, 1 bit: the consumer accepts the result when resp_valid and resp_ready are both high.

Function
REQ-011 SHALL instantiate exactly one 16-bit half-float classifier, fed from an internal 16-bit operand register.
REQ-012 SHALL encode resp_class bits 0..9 as: -inf, -normal, -subnormal, -0, +0, +subnormal, +normal, +inf, sNaN, qNaN; exactly one bit is set whenever resp_valid=1.
REQ-013 SHALL implement a two-state FSM, IDLE and RESP: IDLE has no result held; RESP holds a result with resp_valid=1.
REQ-014 SHALL permit a grant only when the FSM is in IDLE, or in RESP with resp_ready=1 in the same cycle.
REQ-015 SHALL, in a grant-permitted cycle with any req_valid bit set, drive exactly one req_ready bit high, selected per REQ-025/REQ-026, and drive all other req_ready bits low.
REQ-016 SHALL drive req_ready to all zeros when no grant is permitted or no req_valid bit is set; req_ready SHALL never be high for a requester whose req_valid is low.
REQ-017 SHALL, on an accept, capture the operand and its index at the clock edge; the FSM goes to (or stays in) RESP, and the result appears the following cycle (latency 1, throughput 1 per cycle).
REQ-018 SHALL, in RESP with resp_ready=1 and no accept, go to IDLE and drop resp_valid the next cycle.
REQ-019 SHALL, in RESP with resp_ready=0, hold resp_valid, resp_id and resp_class stable and drive req_ready to all zeros.
REQ-020 SHALL drive resp_class to zero whenever resp_valid=0.

Reset
REQ-021 SHALL, with RST high at a clock edge, put the FSM in IDLE, clear the operand register and resp_id to 0, and set the round-robin pointer to NREQ-1.
REQ-022 SHALL drive resp_valid=0, resp_class=0, req_ready=0 in every cycle RST is high, regardless of req_valid.
REQ-023 SHALL discard a held or in-flight result when RST is asserted mid-operation; it is never presented after reset.
REQ-024 SHALL present the first result no earlier than two cycles after RST deasserts (the accept cycle, then the result cycle).

Configuration
REQ-025 SHALL, with macro FCLASS_ARB_RR_EN defined, grant round-robin:
- the search starts at index (last granted + 1) mod NREQ;
- the pointer updates only on an accept.
REQ-026 SHALL, without FCLASS_ARB_RR_EN, grant fixed priority: the lowest set req_valid index wins, and the pointer is unused.

Verification
REQ-027 SHALL cover single requests:
- req 0 sends 0x7C00 -> resp_class=0x080, resp_id=0, one cycle after the accept;
- req 0 sends 0xFC00 -> resp_class=0x001;
- req 0 sends 0x7E00 -> resp_class=0x200;
- req 0 sends 0x7D00 -> resp_class=0x100;
- req 0 sends 0x8000 -> resp_class=0x008;
- req 0 sends 0x0001 -> resp_class=0x020;
- req 0 sends 0x3C00 -> resp_class=0x040.
REQ-028 SHALL cover RR_EN defined: all four requesters valid continuously with resp_ready=1 -> grants in order 0,1,2,3,0, one per cycle, with resp_valid held high.
REQ-029 SHALL cover RR_EN undefined: requesters 1 and 3 valid continuously -> every grant goes to requester 1, and requester 3 never gets req_ready.
REQ-030 SHALL cover back-pressure: resp_ready=0 for 3 cycles while a result is held -> result stable and req_ready=0; on resp_ready=1, the next requester is accepted in that same cycle.
REQ-031 SHALL cover reset mid-operation: RST pulsed while in RESP with resp_ready=0 -> resp_valid=0 the next cycle, and after release requester 0 wins first in both configurations.

Source files
------------

// File: rtl/fclass_arbiter_16bit.sv
// -----------------------------------------------------------------------------
// fclass_arbiter_16bit
//
// Lets NREQ requesters share a single IEEE-754 half-precision classifier.
// One operand is accepted per grant and captured into an internal operand
// register. Its one-hot class is presented one cycle later, and is held until
// the consumer takes it.
//
// Configuration macro:
//   FCLASS_ARB_RR_EN  defined   -> round-robin grant. The search starts at
//                                   (last granted + 1) mod NREQ.
//                     undefined -> fixed priority. The lowest valid index wins.
//
// Ports:
//   CLK         single clock, rising edge
//   RST         synchronous active-high reset
//   req_valid   [NREQ]     requester i offers an operand
//   req_float   [NREQ*16]  operand of requester i in bits [16i+15:16i]
//   req_ready   [NREQ]     one-hot accept strobe
//   resp_valid             a result is presented
//   resp_id     [clog2]    index of the requester that owns the result
//   resp_class  [10]       one-hot class, in bit order:
//                          -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN
//   resp_ready             consumer takes the result
// -----------------------------------------------------------------------------
module fclass_arbiter_16bit #(
    parameter int NREQ = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*16-1:0]      req_float,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [9:0]              resp_class,
    input  logic                    resp_ready
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic {IDLE, RESP} state_t;

    state_t         state_reg;
    logic [15:0]    op_reg;
    logic [IDW-1:0] id_reg;
    logic [15:0]    float_arr [NREQ];
    logic           grant_ok;
    logic           grant_found;
    logic           accept;
    logic [IDW-1:0] grant_idx;
    logic [9:0]     class_raw;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign float_arr[gi] = req_float[16*gi +: 16];
        end
    endgenerate

    // A new operand may enter when the result slot is empty.
    // It may also enter when the held result is being consumed in this same cycle.
    assign grant_ok = !RST && ((state_reg == IDLE) || resp_ready);

`ifdef FCLASS_ARB_RR_EN
    logic [IDW-1:0] ptr_reg;

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] ptr, input int k);
        int sum;
        sum = int'(ptr) + 1 + k;
        return IDW'(sum % NREQ);
    endfunction

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[rr_index(ptr_reg, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_index(ptr_reg, k);
            end
        end
    end
`else
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(k);
            end
        end
    end
`endif

    // grant_found already implies req_valid[grant_idx], so ready never
    // points at an idle requester.
    assign accept    = grant_ok && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            id_reg    <= '0;
`ifdef FCLASS_ARB_RR_EN
            ptr_reg   <= IDW'(NREQ - 1);
`endif
        end else begin
            if (accept) begin
                state_reg <= RESP;
                op_reg    <= float_arr[grant_idx];
                id_reg    <= grant_idx;
`ifdef FCLASS_ARB_RR_EN
                ptr_reg   <= grant_idx;
`endif
            end else if ((state_reg == RESP) && resp_ready) begin
                state_reg <= IDLE;
            end
        end
    end

    // Half-float classifier; the only one in the block, driven by op_reg.
    always_comb begin
        class_raw = '0;
        if (op_reg[14:10] == 5'h1F) begin
            if (op_reg[9:0] == '0)
                class_raw = op_reg[15] ? 10'h001 : 10'h080;
            else
                class_raw = op_reg[9] ? 10'h200 : 10'h100;   // quiet bit = mantissa MSB
        end else if (op_reg[14:10] == 5'h00) begin
            if (op_reg[9:0] == '0)
                class_raw = op_reg[15] ? 10'h008 : 10'h010;
            else
                class_raw = op_reg[15] ? 10'h004 : 10'h020;
        end else begin
            class_raw = op_reg[15] ? 10'h002 : 10'h040;
        end
    end

    // RST masks the presented result in the same cycle it is asserted.
    assign resp_valid = (state_reg == RESP) && !RST;
    assign resp_class = resp_valid ? class_raw : '0;
    assign resp_id    = id_reg;

endmodule

// File: tb/tb_fclass_arbiter_16bit.sv
module tb_fclass_arbiter_16bit;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*16-1:0]   req_float;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [IDW-1:0]       resp_id;
    logic [9:0]           resp_class;
    logic                 resp_ready;

    typedef struct packed {
        logic [31:0]    cyc;
        logic [IDW-1:0] id;
        logic [9:0]     cls;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc_cnt = '0;

    // Per-requester operands used in the arbitration phases, with their classes.
    logic [15:0] req_tab [NREQ] = '{16'h3C00, 16'h8000, 16'h0001, 16'hFC00};
    logic [9:0]  cls_tab [NREQ] = '{10'h040, 10'h008, 10'h020, 10'h001};

    // Single-request vectors covering all ten classes.
    logic [15:0] sf [10] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7D00, 16'h8000,
                             16'h0001, 16'h3C00, 16'h8001, 16'hBC00, 16'h0000};
    logic [9:0]  sc [10] = '{10'h080, 10'h001, 10'h200, 10'h100, 10'h008,
                             10'h020, 10'h040, 10'h004, 10'h002, 10'h010};

`ifdef FCLASS_ARB_RR_EN
    int exp_all [5] = '{0, 1, 2, 3, 0};
    int exp_13  [4] = '{1, 3, 1, 3};
`else
    int exp_all [5] = '{0, 0, 0, 0, 0};
    int exp_13  [4] = '{1, 1, 1, 1};
`endif

    fclass_arbiter_16bit #(.NREQ(NREQ)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_float  (req_float),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_class (resp_class),
        .resp_ready (resp_ready)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [IDW-1:0] oh_idx(input logic [NREQ-1:0] oh);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) r = IDW'(i);
        return r;
    endfunction

    // Monitor: the front entry is expected from its due cycle onward.
    // It is retired when the consumer takes it.
    always @(negedge CLK) begin
        if (sb_q.size() != 0 && sb_q[0].cyc <= cyc_cnt) begin
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_id", 32'(resp_id), 32'(sb_q[0].id));
            check("resp_class", 32'(resp_class), 32'(sb_q[0].cls));
            if (resp_ready) begin
                $display("resp  id=%0d class=%03h cycle=%0d", resp_id, resp_class, cyc_cnt);
                void'(sb_q.pop_front());
            end
        end else begin
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
            check("idle_resp_class", 32'(resp_class), 32'd0);
        end
    end

    // One clock cycle: drive inputs, check req_ready mid-cycle.
    // On an expected accept, queue the expected result for the next cycle.
    task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic rst,
                        input logic [NREQ-1:0] exp_ready, input logic [9:0] exp_cls,
                        input string name);
        exp_t e;
        req_valid  = v;
        resp_ready = rdy;
        RST        = rst;
        if (rst) sb_q.delete();
        @(negedge CLK);
        check({name, "_req_ready"}, 32'(req_ready), 32'(exp_ready));
        if (exp_ready != '0) begin
            e.cyc = cyc_cnt + 1;
            e.id  = oh_idx(exp_ready);
            e.cls = exp_cls;
            sb_q.push_back(e);
            $display("grant %s id=%0d cycle=%0d", name, e.id, cyc_cnt);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        req_valid  = '0;
        req_float  = '0;
        resp_ready = 1'b1;
        RST        = 1'b1;

        // Reset with every requester asking.
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 10'h0, "reset0");
        check("reset_id", 32'(resp_id), 32'd0);
        step(4'b1111, 1'b1, 1'b1, 4'b0000, 10'h0, "reset1");

        // Single requests, back to back, from requester 0.
        for (int i = 0; i < 10; i++) begin
            req_float[15:0] = sf[i];
            step(4'b0001, 1'b1, 1'b0, 4'b0001, sc[i], "single");
        end
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 10'h0, "idle");

        // Arbitration from a fresh reset.
        for (int i = 0; i < NREQ; i++) req_float[16*i +: 16] = req_tab[i];
        step(4'b0000, 1'b1, 1'b1, 4'b0000, 10'h0, "reset2");
        for (int i = 0; i < 5; i++)
            step(4'b1111, 1'b1, 1'b0, NREQ'(1) << exp_all[i], cls_tab[exp_all[i]], "all4");
        for (int i = 0; i < 4; i++)
            step(4'b1010, 1'b1, 1'b0, NREQ'(1) << exp_13[i], cls_tab[exp_13[i]], "req13");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 10'h0, "idle");

        // Back-pressure: hold for three cycles, then accept in the release cycle.
        step(4'b0001, 1'b1, 1'b0, 4'b0001, cls_tab[0], "bp_first");
        for (int i = 0; i < 3; i++)
            step(4'b1110, 1'b0, 1'b0, 4'b0000, 10'h0, "bp_hold");
        step(4'b1110, 1'b1, 1'b0, 4'b0010, cls_tab[1], "bp_release");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 10'h0, "idle");

        // Reset while a result is held.
        step(4'b0010, 1'b1, 1'b0, 4'b0010, cls_tab[1], "mr_accept");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 10'h0, "mr_hold");
        step(4'b1111, 1'b0, 1'b1, 4'b0000, 10'h0, "mr_reset");
        check("mr_reset_id", 32'(resp_id), 32'd0);
        step(4'b1111, 1'b1, 1'b0, 4'b0001, cls_tab[0], "mr_after");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 10'h0, "idle");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 10'h0, "idle");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
